// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD digit sender.
// States, the BCD digit limit and a digit validity test.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_nibble_check.sv
// Replaces non-BCD nibbles with zero and flags their presence.
// Built only when BCD_CHECK_EN is defined.
`ifdef BCD_CHECK_EN
module bcd_nibble_check
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] word,
  output logic [4*NDIG-1:0] clean,
  output logic              bad
);

  always_comb begin
    clean = word;
    bad   = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!is_bcd(word[4*i +: 4])) begin
        clean[4*i +: 4] = 4'd0;
        bad             = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/bcd_digit_sender.sv
// Serialises a packed BCD word, MS digit first, with a rotating strobe.
// Define BCD_CHECK_EN to sanitise invalid digits and raise err.
module bcd_digit_sender
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  output logic [3:0]        digit,
  output logic [NDIG-1:0]   en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W  = 4 * NDIG;
  localparam int IW = $clog2(NDIG);
  localparam logic [NDIG-1:0] EN_FIRST =
    {1'b1, {(NDIG-1){1'b0}}};

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    sreg;
  logic [W-1:0]    word;
  logic            take;
  logic            last;

  assign in_ready = (state != SEND);
  assign busy     = (state == SEND);
  assign done     = (state == DONE);
  assign take     = in_valid && in_ready;
  assign last     = (idx == '0);

`ifdef BCD_CHECK_EN
  logic bad;

  bcd_nibble_check #(
    .NDIG (NDIG)
  ) u_check (
    .word  (in_data),
    .clean (word),
    .bad   (bad)
  );

  // err follows the most recently accepted word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (take) begin
      err <= bad;
    end
  end
`else
  assign word = in_data;
  assign err  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = SEND;
      SEND:    if (last) state_nxt = DONE;
      DONE:    state_nxt = take ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      sreg  <= '0;
      digit <= '0;
      en    <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        idx   <= IW'(NDIG - 1);
        digit <= word[W-1 -: 4];
        sreg  <= word << 4;
        en    <= EN_FIRST;
      end else if (state == SEND) begin
        if (last) begin
          digit <= '0;
          en    <= '0;
        end else begin
          idx   <= idx - IW'(1);
          digit <= sreg[W-1 -: 4];
          sreg  <= sreg << 4;
          en    <= en >> 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_sender.sv
// Scoreboard bench for bcd_digit_sender (NDIG=4).
// Expected strobe/digit pairs are queued at acceptance, popped on en.
module tb_bcd_digit_sender;

  localparam int NDIG = 4;

  typedef struct packed {
    logic [NDIG-1:0] en;
    logic [3:0]      digit;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] in_data;
  logic [3:0]        digit;
  logic [NDIG-1:0]   en;
  logic              busy;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int t5       = -1;
  int t9       = -1;
  beat_t sb[$];

  bcd_digit_sender #(
    .NDIG (NDIG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .digit    (digit),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_nib(input logic [3:0] n);
`ifdef BCD_CHECK_EN
    return (n > 4'd9) ? 4'd0 : n;
`else
    return n;
`endif
  endfunction

  task automatic push_word(input logic [4*NDIG-1:0] w);
    beat_t b;
    for (int k = 0; k < NDIG; k++) begin
      b.en    = '0;
      b.en[NDIG-1-k] = 1'b1;
      b.digit = model_nib(w[4*(NDIG-1-k) +: 4]);
      sb.push_back(b);
    end
    exp_done++;
  endtask

  // Offer a word; returns just after the accepting edge.
  task automatic send(input logic [4*NDIG-1:0] w);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        push_word(w);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (done) done_cnt++;
    chk("busy_vs_en", 32'(busy), 32'(en != '0));
    if (en != '0) begin
      chk("en_onehot", 32'($onehot(en)), 32'd1);
      if (en[NDIG-1] && digit == 4'd5 && t5 < 0) t5 = cyc;
      if (en[NDIG-1] && digit == 4'd9 && t9 < 0) t9 = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'({en, digit}), 32'd0);
      end else begin
        b = sb.pop_front();
        chk("beat", 32'({en, digit}), 32'(b));
      end
    end
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);

    // single word, one-cycle valid
    send(16'h1234);
    @(negedge clk);
    in_valid = 1'b0;
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("s_last_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("d_done", 32'(done), 32'd1);
    chk("d_ready", 32'(in_ready), 32'd1);
    chk("d_en", 32'(en), 32'd0);
    @(negedge clk);
    chk("i_done", 32'(done), 32'd0);
    chk("i_busy", 32'(busy), 32'd0);

    // back-to-back with valid held
    t5 = -1;
    t9 = -1;
    send(16'h5678);
    @(negedge clk);
    in_data = 16'h9012;
    send(16'h9012);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_gap", 32'(t9 - t5), 32'd5);

    // valid during SEND is ignored
    send(16'h2468);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    chk("ign_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_idle", 32'(busy), 32'd0);

    // reset during third digit
    send(16'h4321);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_en", 32'(en), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_digit", 32'(digit), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    sb.delete();
    exp_done--;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0987;
    #2 rst = 1'b1;
    send(16'h0987);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // invalid digits
    send(16'h1A3F);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifdef BCD_CHECK_EN
    chk("err_set", 32'(err), 32'd1);
`else
    chk("err_off", 32'(err), 32'd0);
`endif
    send(16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
